// File: rtl/delay_pipe.sv
// delay_pipe: DEPTH-stage registered delay line with per-stage valid bits and a registered occupancy count.
// Define DELAY_PIPE_ASSERT_EN to compile in the latency / occupancy checker; ports and function are unchanged.
module delay_pipe #(
  parameter int              WIDTH = 8,
  parameter int              DEPTH = 4,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       CE,
  input  logic                       FLUSH,
  input  logic                       I_VALID,
  input  logic [WIDTH-1:0]           I,
  output logic                       O_VALID,
  output logic [WIDTH-1:0]           O,
  output logic [$clog2(DEPTH+1)-1:0] OCC
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [OCC_W-1:0] occ_q;

  // Data follows CE alone; FLUSH only touches the valid bits and the count.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < DEPTH; k++) data_q[k] <= INIT;
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      if (CE) begin
        data_q[0] <= I;
        for (int k = 1; k < DEPTH; k++) data_q[k] <= data_q[k-1];
      end
      if (FLUSH) begin
        valid_q <= '0;
        occ_q   <= '0;
      end else if (CE) begin
        valid_q[0] <= I_VALID;
        for (int k = 1; k < DEPTH; k++) valid_q[k] <= valid_q[k-1];
        occ_q <= occ_q + OCC_W'(I_VALID) - OCC_W'(valid_q[DEPTH-1]);
      end
    end
  end

  assign O       = data_q[DEPTH-1];
  assign O_VALID = valid_q[DEPTH-1];
  assign OCC     = occ_q;

`ifdef DELAY_PIPE_ASSERT_EN
  // Bit k set: the edge k+1 cycles ago was a clean advance (CE high, no flush, no reset).
  logic [DEPTH-1:0] adv_hist_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      adv_hist_q <= '0;
    end else begin
      adv_hist_q[0] <= CE && !FLUSH;
      for (int k = 1; k < DEPTH; k++) adv_hist_q[k] <= adv_hist_q[k-1];
    end
  end

  a_latency: assert property (@(posedge CLK) disable iff (RESET || FLUSH)
    (&adv_hist_q && $past(I_VALID, DEPTH)) |-> (O_VALID && O == $past(I, DEPTH)));

  a_occ_max: assert property (@(posedge CLK) disable iff (RESET)
    OCC <= OCC_W'(DEPTH));
`endif

endmodule

// File: doc/delay_pipe.md
DELAY_PIPE -- requirements
Module: delay_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data bits per stage (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 4, number of register stages (>=1).
REQ-003 The block SHALL have parameter INIT, default 0, WIDTH-bit reset value of every data stage.
REQ-004 The block SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-005 The block SHALL have port RESET  input  1  reset; synchronous and active-high.
REQ-006 The block SHALL have port CE  input  1  advance enable; 0 holds all stages.
REQ-007 The block SHALL have port FLUSH  input  1  invalidates all stages.
REQ-008 The block SHALL have port I_VALID  input  1  qualifies I.
REQ-009 The block SHALL have port I  input  WIDTH  data in.
REQ-010 The block SHALL have port O_VALID  output  1  valid bit of last stage.
REQ-011 The block SHALL have port O  output  WIDTH  data of last stage.
REQ-012 The block SHALL have port OCC  output  $clog2(DEPTH+1)  count of valid stages.

Function
REQ-013 The block SHALL hold DEPTH data registers and DEPTH valid bits, stage 0 fed from I/I_VALID, stage DEPTH-1 driving O/O_VALID directly (no combinational path from I to O).
REQ-014 With CE=1, FLUSH=0, RESET=0, each edge SHALL load stage0<=I, valid0<=I_VALID, and stage k<=stage k-1, valid k<=valid k-1 for k=1..DEPTH-1.
REQ-015 With CE held high, a sample presented at edge n SHALL appear on O at edge n+DEPTH (latency DEPTH cycles); DEPTH=1 SHALL equal a single register.
REQ-016 With CE=0 and FLUSH=0, all data, valid bits and OCC SHALL hold.
REQ-017 Data registers SHALL shift on CE=1 regardless of valid bits; O SHALL carry stale data when O_VALID=0.
REQ-018 FLUSH=1 SHALL clear every valid bit (including the stage-0 load at that edge) regardless of CE; data registers SHALL follow CE unchanged.
REQ-019 OCC SHALL be registered and equal the number of set valid bits after every edge: with CE=1, OCC_next = OCC + I_VALID - O_VALID; FLUSH sets OCC to 0.
REQ-020 OCC SHALL never exceed DEPTH; I_VALID=1 with a full, non-draining pipe is legal because the oldest valid leaves at the same edge.
REQ-021 Priority SHALL be RESET > FLUSH > CE.

Reset
REQ-022 RESET=1 at an edge SHALL set all data stages to INIT, all valid bits to 0, OCC to 0, independent of CE and FLUSH.
REQ-023 After reset O SHALL equal INIT, O_VALID 0, OCC 0; RESET asserted mid-stream SHALL discard all in-flight samples.
REQ-024 The first I_VALID sample accepted in the cycle after RESET deasserts SHALL emerge DEPTH CE-cycles later.

Configuration
REQ-025 Macro DELAY_PIPE_ASSERT_EN defined SHALL compile in a checker clocked on CLK, disabled while RESET or FLUSH is high during the window, asserting: when CE stays 1 for DEPTH cycles, I_VALID |-> ##DEPTH (O_VALID && O == $past(I, DEPTH)); and OCC <= DEPTH always.
REQ-026 Macro DELAY_PIPE_ASSERT_EN undefined SHALL leave no checker logic; ports and function SHALL be identical in both builds.

Verification
REQ-027 WIDTH=8, DEPTH=4, CE=1, I_VALID=1, I=0x11,0x22,0x33,... -> O_VALID rises at edge 4, O=0x11,0x22,0x33 on successive cycles, OCC ramps 1..4 then holds 4.
REQ-028 Fill 4 samples, CE=0 for 3 cycles -> O, O_VALID, OCC unchanged; CE=1 resumes -> order preserved, no loss or duplication.
REQ-029 OCC=3 with CE=1 and FLUSH=1 -> next cycle OCC=0, O_VALID=0 for 4 cycles; I_VALID at flush edge is dropped.
REQ-030 Mid-stream RESET with INIT=0xA5 -> next cycle O=0xA5, O_VALID=0, OCC=0; first post-reset sample out after 4 cycles.
REQ-031 DEPTH=1, WIDTH=1, I toggling with I_VALID=1 -> O equals I delayed one cycle, OCC constant 1.
REQ-032 Build with DELAY_PIPE_ASSERT_EN, random CE/I_VALID/FLUSH/RESET for 10000 cycles against a queue model -> no assertion failures, outputs match model.
